// File: rtl/normal_eq_accum_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | normal_eq_accum_if : sample stream and result bus of normal_eq_accum |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface normal_eq_accum_if #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
);
    logic                    start;
    logic                    sample_valid;
    logic                    sample_ready;
    logic signed [WIDTH-1:0] sample_x;
    logic signed [WIDTH-1:0] sample_y;
    logic                    sample_last;
    logic signed [WIDTH-1:0] A_flat [0:8];
    logic signed [WIDTH-1:0] B_flat [0:2];
    logic [CNT_WIDTH-1:0]    sample_count;
    logic                    sat;
    logic                    done;

    modport master (
        output start, sample_valid, sample_x, sample_y, sample_last,
        input  sample_ready, A_flat, B_flat, sample_count, sat, done
    );

    modport slave (
        input  start, sample_valid, sample_x, sample_y, sample_last,
        output sample_ready, A_flat, B_flat, sample_count, sat, done
    );
endinterface
`default_nettype wire

// File: rtl/normal_eq_accum.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | normal_eq_accum : builds 3x3 quadratic-basis normal equations A, B  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module normal_eq_accum #(
    parameter int WIDTH       = 32,
    parameter int FRAC        = 16,
    parameter int ACC_WIDTH   = 48,
    parameter int CNT_WIDTH   = 16,
    parameter int MUL_LATENCY = 2
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    normal_eq_accum_if.slave  bus
);
    localparam int c_pw = 2 * WIDTH;
    localparam int c_ml = MUL_LATENCY;
    localparam logic [c_ml-1:0] c_v2_early = ~(c_ml'(1) << (c_ml - 1));
    localparam logic signed [ACC_WIDTH-1:0] c_acc_max =
        {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_acc_min = ~c_acc_max;
    localparam logic [WIDTH-1:0] c_out_max = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_out_min = {1'b1, {(WIDTH-1){1'b0}}};

    typedef logic signed [c_pw-1:0]      word_t;
    typedef logic signed [ACC_WIDTH-1:0] acc_t;
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACCUM    = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_FINALIZE = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Full double-width product, arithmetic shift by FRAC, low word kept.
    function automatic word_t fx_mul(input word_t a, input word_t b);
        logic signed [2*c_pw-1:0] full;
        full = $signed({{c_pw{a[c_pw-1]}}, a}) * $signed({{c_pw{b[c_pw-1]}}, b});
        return c_pw'(full >>> FRAC);
    endfunction

    // Returns {clipped, saturated word}.
    function automatic logic [WIDTH:0] clip(input acc_t v);
        if (v > c_acc_max)      return {1'b1, c_out_max};
        else if (v < c_acc_min) return {1'b1, c_out_min};
        else                    return {1'b0, v[WIDTH-1:0]};
    endfunction

    state_t r_state, w_next;
    logic   w_ready, w_done, w_accept, w_busy_early;

    logic  r_s0_v;
    word_t r_s0_x, r_s0_y;
    logic  [c_ml-1:0] r_v1, r_v2;
    word_t r_s1_x [c_ml], r_s1_y [c_ml], r_s1_x2 [c_ml], r_s1_xy [c_ml];
    word_t r_s2_x [c_ml], r_s2_y [c_ml], r_s2_x2 [c_ml], r_s2_xy [c_ml];
    word_t r_s2_x3 [c_ml], r_s2_x4 [c_ml], r_s2_x2y [c_ml];

    acc_t r_sx, r_sx2, r_sx3, r_sx4, r_sy, r_sxy, r_sx2y;
    logic [CNT_WIDTH-1:0]    r_count;
    logic signed [WIDTH-1:0] r_a [0:8];
    logic signed [WIDTH-1:0] r_b [0:2];
    logic                    r_sat;
    acc_t                    w_n_acc;
    logic [WIDTH:0]          w_clip [8];
    logic                    w_any_clip;

    assign w_accept     = (r_state == ST_ACCUM) && bus.sample_valid;
    // Everything ahead of the last multiply stage has drained.
    assign w_busy_early = r_s0_v | (|r_v1) | (|(r_v2 & c_v2_early));

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            ST_IDLE:     if (bus.start) w_next = ST_ACCUM;
            ST_ACCUM: begin
                w_ready = 1'b1;
                if (bus.sample_valid && bus.sample_last) w_next = ST_DRAIN;
            end
            ST_DRAIN:    if (!w_busy_early) w_next = ST_FINALIZE;
            ST_FINALIZE: w_next = ST_DONE;
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default:     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s0_v <= 1'b0;
            r_v1   <= '0;
            r_v2   <= '0;
        end else begin
            r_s0_v  <= w_accept;
            r_v1[0] <= r_s0_v;
            r_v2[0] <= r_v1[c_ml-1];
            for (int i = 1; i < c_ml; i++) begin
                r_v1[i] <= r_v1[i-1];
                r_v2[i] <= r_v2[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_s0_x      <= c_pw'(bus.sample_x);
        r_s0_y      <= c_pw'(bus.sample_y);
        r_s1_x[0]   <= r_s0_x;
        r_s1_y[0]   <= r_s0_y;
        r_s1_x2[0]  <= fx_mul(r_s0_x, r_s0_x);
        r_s1_xy[0]  <= fx_mul(r_s0_x, r_s0_y);
        r_s2_x[0]   <= r_s1_x[c_ml-1];
        r_s2_y[0]   <= r_s1_y[c_ml-1];
        r_s2_x2[0]  <= r_s1_x2[c_ml-1];
        r_s2_xy[0]  <= r_s1_xy[c_ml-1];
        r_s2_x3[0]  <= fx_mul(r_s1_x2[c_ml-1], r_s1_x[c_ml-1]);
        r_s2_x4[0]  <= fx_mul(r_s1_x2[c_ml-1], r_s1_x2[c_ml-1]);
        r_s2_x2y[0] <= fx_mul(r_s1_x2[c_ml-1], r_s1_y[c_ml-1]);
        for (int i = 1; i < c_ml; i++) begin
            r_s1_x[i]   <= r_s1_x[i-1];
            r_s1_y[i]   <= r_s1_y[i-1];
            r_s1_x2[i]  <= r_s1_x2[i-1];
            r_s1_xy[i]  <= r_s1_xy[i-1];
            r_s2_x[i]   <= r_s2_x[i-1];
            r_s2_y[i]   <= r_s2_y[i-1];
            r_s2_x2[i]  <= r_s2_x2[i-1];
            r_s2_xy[i]  <= r_s2_xy[i-1];
            r_s2_x3[i]  <= r_s2_x3[i-1];
            r_s2_x4[i]  <= r_s2_x4[i-1];
            r_s2_x2y[i] <= r_s2_x2y[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || (r_state == ST_IDLE && bus.start)) begin
            r_sx <= '0; r_sx2 <= '0; r_sx3 <= '0; r_sx4 <= '0;
            r_sy <= '0; r_sxy <= '0; r_sx2y <= '0;
            r_count <= '0;
        end else begin
            if (w_accept && r_count != '1) r_count <= r_count + CNT_WIDTH'(1);
            if (r_v2[c_ml-1]) begin
                r_sx   <= r_sx   + ACC_WIDTH'(r_s2_x[c_ml-1]);
                r_sy   <= r_sy   + ACC_WIDTH'(r_s2_y[c_ml-1]);
                r_sx2  <= r_sx2  + ACC_WIDTH'(r_s2_x2[c_ml-1]);
                r_sxy  <= r_sxy  + ACC_WIDTH'(r_s2_xy[c_ml-1]);
                r_sx3  <= r_sx3  + ACC_WIDTH'(r_s2_x3[c_ml-1]);
                r_sx4  <= r_sx4  + ACC_WIDTH'(r_s2_x4[c_ml-1]);
                r_sx2y <= r_sx2y + ACC_WIDTH'(r_s2_x2y[c_ml-1]);
            end
        end
    end

    always_comb begin
        w_n_acc    = ACC_WIDTH'(r_count) << FRAC;
        w_clip[0]  = clip(w_n_acc);
        w_clip[1]  = clip(r_sx);
        w_clip[2]  = clip(r_sx2);
        w_clip[3]  = clip(r_sx3);
        w_clip[4]  = clip(r_sx4);
        w_clip[5]  = clip(r_sy);
        w_clip[6]  = clip(r_sxy);
        w_clip[7]  = clip(r_sx2y);
        w_any_clip = 1'b0;
        for (int i = 0; i < 8; i++) w_any_clip = w_any_clip | w_clip[i][WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a   <= '{default: '0};
            r_b   <= '{default: '0};
            r_sat <= 1'b0;
        end else if (r_state == ST_IDLE && bus.start) begin
            r_sat <= 1'b0;
        end else if (r_state == ST_FINALIZE) begin
            r_a[0] <= w_clip[0][WIDTH-1:0];
            r_a[1] <= w_clip[1][WIDTH-1:0];
            r_a[2] <= w_clip[2][WIDTH-1:0];
            r_a[3] <= w_clip[1][WIDTH-1:0];
            r_a[4] <= w_clip[2][WIDTH-1:0];
            r_a[5] <= w_clip[3][WIDTH-1:0];
            r_a[6] <= w_clip[2][WIDTH-1:0];
            r_a[7] <= w_clip[3][WIDTH-1:0];
            r_a[8] <= w_clip[4][WIDTH-1:0];
            r_b[0] <= w_clip[5][WIDTH-1:0];
            r_b[1] <= w_clip[6][WIDTH-1:0];
            r_b[2] <= w_clip[7][WIDTH-1:0];
            r_sat  <= w_any_clip;
        end
    end

    for (genvar gi = 0; gi < 9; gi++) begin : g_a_out
        assign bus.A_flat[gi] = r_a[gi];
    end
    for (genvar gi = 0; gi < 3; gi++) begin : g_b_out
        assign bus.B_flat[gi] = r_b[gi];
    end

    assign bus.sample_ready = w_ready;
    assign bus.done         = w_done;
    assign bus.sample_count = r_count;
    assign bus.sat          = r_sat;
endmodule
`default_nettype wire

// File: doc/normal_eq_accum.md
# normal_eq_accum

Streaming accumulator that builds the 3x3 normal-equation system for the quadratic LSM continuation-value regression (basis 1, x, x²) from per-path samples. It produces A = ΣφφᵀA and B = Σφy in the flattened row-major form the downstream 3x3 regression solver consumes, then pulses `done` to launch the solve. It sits between the path/cash-flow generator and the regression solver, once per exercise date.

## Interface
- WIDTH, 32: signed fixed-point word width of samples and outputs.
- FRAC, 16: fractional bits (Q(WIDTH-FRAC).FRAC).
- ACC_WIDTH, 48: internal signed accumulator width, must be ≥ WIDTH+CNT_WIDTH.
- CNT_WIDTH, 16: sample counter width.
- MUL_LATENCY, 2: pipeline depth of each fixed-point multiply stage.

- clk  in  1  rising-edge clock.
- rst_n  in  1  one clock; reset is synchronous and active-low.
- start  in  1  begin a new batch; sampled only in IDLE.
- sample_valid  in  1  sample present.
- sample_ready  out  1  block accepts a sample this cycle.
- sample_x  in  WIDTH  signed underlying price (basis variable).
- sample_y  in  WIDTH  signed discounted realised cash flow.
- sample_last  in  1  final sample of batch; qualified by valid&&ready.
- A_flat[0:8]  out  WIDTH each  row-major A, signed fixed-point.
- B_flat[0:2]  out  WIDTH each  B, signed fixed-point.
- sample_count  out  CNT_WIDTH  samples accepted in current/last batch.
- sat  out  1  sticky: some output saturated in last batch.
- done  out  1  one-cycle pulse, outputs valid.

## Operation
- States: IDLE, ACCUM, DRAIN, FINALIZE, DONE.
- IDLE: sample_ready=0. start=1 → ACCUM; same edge clears accumulators, sample_count, sat. Outputs hold previous batch values.
- ACCUM: sample_ready=1. Accept on sample_valid&&sample_ready; accept with sample_last=1 → DRAIN. start ignored.
- Pipeline stage 1: x2=x·x, xy=x·y. Stage 2: x3=x2·x, x4=x2·x2, x2y=x2·y. Each product = full 2·WIDTH signed product >>> FRAC (arithmetic shift, truncate toward −∞), kept at full width, no saturation internally. Fully pipelined, one sample/cycle.
- Accumulators (ACC_WIDTH, wrap on overflow, which is out of contract): Sx, Sx2, Sx3, Sx4, Sy, Sxy, Sx2y; count sample_count (saturates at all-ones).
- DRAIN: sample_ready=0; wait until pipeline valid shift register is empty and last add done → FINALIZE.
- FINALIZE: saturate each sum to [−2^(WIDTH−1), 2^(WIDTH−1)−1]; N = sample_count<<FRAC saturated likewise. A_flat = {N,Sx,Sx2, Sx,Sx2,Sx3, Sx2,Sx3,Sx4}; B_flat = {Sy,Sxy,Sx2y}. Any clip sets sat. → DONE.
- DONE: done=1 one cycle → IDLE.
- Reset (rst_n=0 at an edge, any state): state=IDLE, pipeline valids cleared, accumulators, A_flat, B_flat, sample_count, sat, done, sample_ready all 0. Samples in flight discarded.

## Timing
- Accept-to-accumulate latency: 2·MUL_LATENCY+1 edges (fixed, independent of gaps).
- Edge E0 accepts last sample: done=1 and outputs updated on edge E0+2·MUL_LATENCY+2 (E0+6 at default), held high exactly one cycle.
- sample_ready falls the cycle after the last accept; never high outside ACCUM.
- Back-pressure: gaps in sample_valid change only latency to E0, never results.
- start high during done cycle ignored; start next cycle (IDLE) accepted.
- A_flat/B_flat/sat stable from done until the next FINALIZE or reset.

## Test plan
- Samples (x,y)=(1.0,2.0),(2.0,3.0),(3.0,5.0 last), FRAC=16 → A_flat={196608,393216,917504, 393216,917504,2359296, 917504,2359296,6422528}, B_flat={655360,1507328,3866624}, sample_count=3, sat=0, done at E0+6.
- Same batch with random sample_valid gaps (0–5 cycles) → identical outputs; sample_ready only in ACCUM.
- Single sample x=200.0, y=1.0 last → A_flat[0]=65536, A_flat[1]=13107200, A_flat[4..8] x²/x³/x⁴ entries=2147483647, B_flat[2]=2147483647, sat=1.
- x=−2.0, y=−1.5 single sample → A_flat[1]=−131072, A_flat[5]=−524288, B_flat[1]=196608, B_flat[2]=−393216.
- rst_n low for one edge mid-ACCUM after 2 samples → all outputs 0, IDLE; new batch of test 1 then yields test 1 results.
- start pulsed during ACCUM and DRAIN → no effect; back-to-back batches (start in the cycle after done) give independent correct results.
